// File: rtl/ir_nec_tx_controller.sv
// NEC IR frame sequencer: accepts one address/command pair per handshake and
// gates an external carrier into a complete NEC frame, followed by a minimum
// idle gap. The carrier divider is held in reset whenever no mark is being
// sent, so every mark starts on a fresh carrier phase.
module ir_nec_tx_controller #(
  parameter int UNIT_CYCLES = 28125,
  parameter int UNIT_W      = 15,
  parameter int GAP_UNITS   = 72
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_addr,
  input  logic [7:0] tx_cmd,
  input  logic       carrier_in,
  output logic       carrier_rst,
  output logic       ir_out,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } state_t;

  localparam logic [UNIT_W-1:0] CYC_LAST  = UNIT_W'(UNIT_CYCLES - 1);
  localparam logic [15:0]       LEAD_MK_L = 16'd15;
  localparam logic [15:0]       LEAD_SP_L = 16'd7;
  localparam logic [15:0]       ONE_L     = 16'd0;
  localparam logic [15:0]       THREE_L   = 16'd2;
  localparam logic [15:0]       GAP_L     = 16'(GAP_UNITS - 1);

  state_t            state;
  state_t            state_next;
  logic [UNIT_W-1:0] cyc;
  logic [15:0]       units;
  logic [4:0]        bit_idx;
  logic [31:0]       shreg;
  logic [15:0]       dur_last;
  logic              tick;
  logic              expire;
  logic              mark;
  logic              xfer;

  // State register; reset aborts any frame in progress immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Per-state duration, expiry detection, next-state and output decode.
  always_comb begin
    state_next = state;
    mark       = 1'b0;
    dur_last   = ONE_L;
    tick       = (cyc == CYC_LAST);
    case (state)
      LEAD_MARK:  begin dur_last = LEAD_MK_L; mark = 1'b1; end
      LEAD_SPACE: dur_last = LEAD_SP_L;
      BIT_MARK:   begin dur_last = ONE_L; mark = 1'b1; end
      BIT_SPACE:  dur_last = shreg[0] ? THREE_L : ONE_L;
      STOP_MARK:  begin dur_last = ONE_L; mark = 1'b1; end
      GAP:        dur_last = GAP_L;
      default:    dur_last = ONE_L;
    endcase
    expire = tick && (units == dur_last);
    xfer   = (state == IDLE) && tx_valid;
    case (state)
      IDLE:       if (tx_valid) state_next = LEAD_MARK;
      LEAD_MARK:  if (expire) state_next = LEAD_SPACE;
      LEAD_SPACE: if (expire) state_next = BIT_MARK;
      BIT_MARK:   if (expire) state_next = BIT_SPACE;
      BIT_SPACE:  if (expire) state_next = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (expire) state_next = GAP;
      GAP:        if (expire) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    tx_ready    = (state == IDLE);
    busy        = (state != IDLE);
    done        = (state == STOP_MARK) && expire;
    carrier_rst = ~mark;
    ir_out      = mark & carrier_in;
  end

  // Timing counters, bit index and payload shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc     <= '0;
      units   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == IDLE) begin
      cyc     <= '0;
      units   <= '0;
      bit_idx <= '0;
      if (xfer) shreg <= {~tx_cmd, tx_cmd, ~tx_addr, tx_addr};
    end else begin
      if (expire) begin
        cyc   <= '0;
        units <= '0;
      end else if (tick) begin
        cyc   <= '0;
        units <= units + 16'd1;
      end else begin
        cyc <= cyc + 1'b1;
      end
      if ((state == BIT_SPACE) && expire) begin
        shreg   <= {1'b0, shreg[31:1]};
        bit_idx <= bit_idx + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_tx_controller.sv
// Directed bench for ir_nec_tx_controller with short NEC units: decodes the
// emitted pulse-distance stream and checks frame timing and carrier gating.
module tb_ir_nec_tx_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_addr = 8'h00;
  logic [7:0] tx_cmd = 8'h00;
  logic       carrier_in = 1'b0;
  logic       carrier_rst;
  logic       ir_out;
  logic       busy;
  logic       done;

  int     checks = 0;
  int     failures = 0;
  longint cyc_cnt = 0;

  ir_nec_tx_controller #(.UNIT_CYCLES(4), .UNIT_W(15), .GAP_UNITS(2)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_addr(tx_addr), .tx_cmd(tx_cmd), .carrier_in(carrier_in),
    .carrier_rst(carrier_rst), .ir_out(ir_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Square-wave carrier, changing away from both clock edges.
  always @(posedge clk) begin
    #2 carrier_in = ~carrier_in;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic [7:0]  addr;
    logic [7:0]  cmd;
    logic [31:0] exp_word;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sends one frame and decodes everything seen while busy.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] c,
                            input bit hold, input bit chg,
                            output logic [31:0] word, output int blen,
                            output int didx, output int dcnt,
                            output int gerr, output int ferr,
                            output longint tx_t);
    int  rl[$];
    bit  rv[$];
    int  cur;
    int  i;
    int  w;
    bit  lvl;
    bit  m;
    word = '0; blen = 0; didx = -1; dcnt = 0; gerr = 0; ferr = 0; tx_t = 0;
    cur = 0; lvl = 1'b0;
    tx_addr = a; tx_cmd = c; tx_valid = 1'b1;
    w = 0;
    while (!tx_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!tx_ready) ferr++;
    @(posedge clk);
    #1;
    tx_t = cyc_cnt;
    if (!hold) tx_valid = 1'b0;
    i = 0;
    while (i < 2000) begin
      @(negedge clk);
      if (!busy) break;
      m = ~carrier_rst;
      if (m && (ir_out !== carrier_in)) gerr++;
      if (!m && (ir_out !== 1'b0)) gerr++;
      if (tx_ready !== 1'b0) gerr++;
      if (done) begin
        dcnt++;
        didx = i;
      end
      if (chg && i == 100) begin
        tx_addr = ~a;
        tx_cmd  = ~c;
      end
      if (i == 0) begin
        lvl = m; cur = 1;
      end else if (m == lvl) begin
        cur++;
      end else begin
        rl.push_back(cur); rv.push_back(lvl);
        lvl = m; cur = 1;
      end
      i++;
    end
    rl.push_back(cur); rv.push_back(lvl);
    blen = i;
    if (rl.size() != 68) begin
      ferr++;
    end else begin
      if (!(rv[0] && rl[0] == 64)) ferr++;
      if (!(!rv[1] && rl[1] == 32)) ferr++;
      for (int b = 0; b < 32; b++) begin
        if (!(rv[2+2*b] && rl[2+2*b] == 4)) ferr++;
        if (rv[3+2*b]) ferr++;
        else if (rl[3+2*b] == 12) word[b] = 1'b1;
        else if (rl[3+2*b] != 4) ferr++;
      end
      if (!(rv[66] && rl[66] == 4)) ferr++;
      if (!(!rv[67] && rl[67] == 8)) ferr++;
    end
  endtask

  vec_t        vecs[3];
  logic [31:0] word;
  int          blen, didx, dcnt, gerr, ferr;
  longint      t1, t2;
  int          e_rdy, e_rst, e_ir, e_busy;

  initial begin
    vecs[0] = '{addr: 8'h00, cmd: 8'hFF, exp_word: 32'h00FFFF00};
    vecs[1] = '{addr: 8'h5A, cmd: 8'h3C, exp_word: 32'hC33CA55A};
    vecs[2] = '{addr: 8'h01, cmd: 8'h80, exp_word: 32'h7F80FE01};

    // Reset values and quiet idle.
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_carrier_rst", carrier_rst, 1);
    check("rst_ir_out", ir_out, 0);
    reset = 1'b0;
    e_rdy = 0; e_rst = 0; e_ir = 0; e_busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tx_ready !== 1'b1) e_rdy++;
      if (carrier_rst !== 1'b1) e_rst++;
      if (ir_out !== 1'b0) e_ir++;
      if (busy !== 1'b0 || done !== 1'b0) e_busy++;
    end
    check("idle_ready", e_rdy, 0);
    check("idle_carrier_rst", e_rst, 0);
    check("idle_ir_out", e_ir, 0);
    check("idle_busy", e_busy, 0);

    // Table of single frames.
    for (int v = 0; v < 3; v++) begin
      send_frame(vecs[v].addr, vecs[v].cmd, 1'b0, 1'b0, word, blen, didx, dcnt, gerr, ferr, t1);
      check($sformatf("v%0d_word", v), word, vecs[v].exp_word);
      check($sformatf("v%0d_busy_len", v), blen, 492);
      check($sformatf("v%0d_done_idx", v), didx, 483);
      check($sformatf("v%0d_done_cnt", v), dcnt, 1);
      check($sformatf("v%0d_gating", v), gerr, 0);
      check($sformatf("v%0d_format", v), ferr, 0);
      repeat (3) @(negedge clk);
    end

    // Back-to-back with tx_valid held and inputs changed mid-frame.
    send_frame(8'h5A, 8'h3C, 1'b1, 1'b1, word, blen, didx, dcnt, gerr, ferr, t1);
    check("b2b_first_word", word, 32'hC33CA55A);
    check("b2b_first_len", blen, 492);
    check("b2b_first_format", ferr + gerr, 0);
    send_frame(8'hA5, 8'hC3, 1'b0, 1'b0, word, blen, didx, dcnt, gerr, ferr, t2);
    check("b2b_spacing", t2 - t1, 493);
    check("b2b_second_word", word, 32'h3CC35AA5);
    check("b2b_second_format", ferr + gerr, 0);
    repeat (3) @(negedge clk);

    // Reset during bit 10 of a frame.
    @(negedge clk);
    tx_addr = 8'h00; tx_cmd = 8'hFF; tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (179) @(negedge clk);
    check("pre_abort_marking", carrier_rst, 0);
    reset = 1'b1;
    #1;
    check("abort_ir_out", ir_out, 0);
    check("abort_carrier_rst", carrier_rst, 1);
    check("abort_busy", busy, 0);
    check("abort_ready", tx_ready, 1);
    e_ir = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ir_out !== 1'b0 || carrier_rst !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) e_ir++;
    end
    check("abort_hold_quiet", e_ir, 0);
    reset = 1'b0;
    send_frame(8'h5A, 8'h3C, 1'b0, 1'b0, word, blen, didx, dcnt, gerr, ferr, t1);
    check("post_abort_word", word, 32'hC33CA55A);
    check("post_abort_len", blen, 492);
    check("post_abort_done", dcnt, 1);
    check("post_abort_format", ferr + gerr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
